// File: rtl/plat_color_picker.sv
// rtl/plat_color_picker.sv - per-round ball/platform colour picker driven by a free-running Galois LFSR
// Draws are taken from the live LFSR state each cycle; rejected draws retry until a fallback applies.
module plat_color_picker #(
  parameter int                NUM_PLATS = 4,
  parameter int                COLOR_W   = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 7,
  localparam int               IDX_W     = (NUM_PLATS > 2) ? $clog2(NUM_PLATS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           seed_load,
  input  logic [LFSR_W-1:0]              seed_in,
  output logic                           busy,
  output logic                           done,
  output logic [COLOR_W-1:0]             new_color_ball,
  output logic [NUM_PLATS*COLOR_W-1:0]   new_color_plats,
  output logic [IDX_W-1:0]               match_idx,
  output logic [LFSR_W-1:0]              lfsr_out
);

  localparam int                 TRY_W     = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PLATS - 1);
  localparam logic [IDX_W:0]     PLATS_LIM = (IDX_W + 1)'(NUM_PLATS);
  localparam logic [COLOR_W-1:0] COLOR_MAX = '1;
  localparam logic [COLOR_W-1:0] COLOR_ONE = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] COLOR_TWO = COLOR_W'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_BALL, ST_POS, ST_FILL} state_t;

  state_t                         state, state_next;
  logic [LFSR_W-1:0]              lfsr, lfsr_step;
  logic [TRY_W-1:0]               tries;
  logic [COLOR_W-1:0]             prev_ball, ball_w;
  logic [IDX_W-1:0]               pos_w, k;
  logic [NUM_PLATS*COLOR_W-1:0]   plats_w, plats_upd;
  logic [COLOR_W-1:0]             cand_c, ball_pick, fill_pick;
  logic [IDX_W-1:0]               cand_p, pos_pick;
  logic                           exhausted, pick_done, commit;

  // All-zero is a lock-up state for the shift register, so it is replaced by SEED.
  always_comb begin
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    if (lfsr_step == '0) begin
      lfsr_step = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr <= lfsr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A valid candidate always wins; the fallback only replaces a rejected draw once retries are spent.
  always_comb begin
    cand_c     = lfsr[COLOR_W-1:0];
    cand_p     = lfsr[LFSR_W-1 -: IDX_W];
    exhausted  = (tries == TRY_LIMIT);
    ball_pick  = (prev_ball == COLOR_MAX) ? COLOR_ONE : prev_ball + COLOR_ONE;
    fill_pick  = (ball_w == COLOR_ONE) ? COLOR_TWO : COLOR_ONE;
    pos_pick   = '0;
    pick_done  = 1'b0;
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BALL;
        end
      end
      ST_BALL: begin
        if (cand_c != '0 && cand_c != prev_ball) begin
          ball_pick = cand_c;
          pick_done = 1'b1;
        end else if (exhausted) begin
          pick_done = 1'b1;
        end
        if (pick_done) begin
          state_next = ST_POS;
        end
      end
      ST_POS: begin
        if ({1'b0, cand_p} < PLATS_LIM) begin
          pos_pick  = cand_p;
          pick_done = 1'b1;
        end else if (exhausted) begin
          pick_done = 1'b1;
        end
        if (pick_done) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (k == pos_w) begin
          fill_pick = ball_w;
          pick_done = 1'b1;
        end else if (cand_c != '0 && cand_c != ball_w) begin
          fill_pick = cand_c;
          pick_done = 1'b1;
        end else if (exhausted) begin
          pick_done = 1'b1;
        end
        if (pick_done && k == LAST_IDX) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign commit = (state == ST_FILL) && (state_next == ST_IDLE);

  always_comb begin
    plats_upd = plats_w;
    plats_upd[k*COLOR_W +: COLOR_W] = fill_pick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tries           <= '0;
      ball_w          <= '0;
      pos_w           <= '0;
      k               <= '0;
      plats_w         <= '0;
      prev_ball       <= '0;
      new_color_ball  <= '0;
      new_color_plats <= '0;
      match_idx       <= '0;
      done            <= 1'b0;
    end else begin
      done <= commit;
      if (state == ST_IDLE || pick_done) begin
        tries <= '0;
      end else begin
        tries <= tries + TRY_W'(1);
      end
      case (state)
        ST_BALL: begin
          if (pick_done) begin
            ball_w <= ball_pick;
          end
        end
        ST_POS: begin
          if (pick_done) begin
            pos_w <= pos_pick;
            k     <= '0;
          end
        end
        ST_FILL: begin
          if (pick_done) begin
            plats_w <= plats_upd;
            k       <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
      // The final platform is written on the same edge, so commit takes the updated vector.
      if (commit) begin
        new_color_ball  <= ball_w;
        new_color_plats <= plats_upd;
        match_idx       <= pos_w;
        prev_ball       <= ball_w;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign lfsr_out = lfsr;

endmodule

// File: tb/tb_plat_color_picker.sv
// tb/tb_plat_color_picker.sv - directed and model-predicted checks for plat_color_picker
module tb_plat_color_picker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        busy, done;
  logic [2:0]  ball;
  logic [11:0] plats;
  logic [1:0]  midx;
  logic [15:0] lfsr_out;

  logic        start3 = 1'b0;
  logic        busy3, done3;
  logic [1:0]  ball3;
  logic [5:0]  plats3;
  logic [1:0]  midx3;
  logic [15:0] lfsr3;

  int          total = 0;
  int          bad = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [2:0]  m_prev = '0;
  logic [3:0]  idx_seen = '0;

  plat_color_picker u_dut (
    .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy), .done(done), .new_color_ball(ball), .new_color_plats(plats),
    .match_idx(midx), .lfsr_out(lfsr_out)
  );

  plat_color_picker #(.NUM_PLATS(3), .COLOR_W(2), .MAX_TRIES(0)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .seed_load(1'b0), .seed_in(16'h0000),
    .busy(busy3), .done(done3), .new_color_ball(ball3), .new_color_plats(plats3),
    .match_idx(midx3), .lfsr_out(lfsr3)
  );

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] sin;
    logic [15:0] exp_lfsr;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] n;
    n = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  // Reference round for default parameters, starting from the LFSR state seen in BALL's first cycle.
  function automatic void predict(input logic [15:0] l_in, input logic [2:0] prev,
                                  output logic [2:0] eb, output logic [1:0] ep,
                                  output logic [11:0] epl, output int cyc);
    logic [15:0] l;
    int          tries;
    bit          got;
    l = l_in; cyc = 0; eb = '0; ep = '0; epl = '0;
    tries = 0; got = 0;
    while (!got) begin
      if (l[2:0] != 3'd0 && l[2:0] != prev) begin eb = l[2:0]; got = 1; end
      else if (tries == 7) begin eb = (prev == 3'd7) ? 3'd1 : prev + 3'd1; got = 1; end
      else tries++;
      l = step(l); cyc++;
    end
    ep = l[15:14];
    l = step(l); cyc++;
    for (int j = 0; j < 4; j++) begin
      if (j == int'(ep)) begin
        epl[j*3 +: 3] = eb; l = step(l); cyc++;
      end else begin
        tries = 0; got = 0;
        while (!got) begin
          if (l[2:0] != 3'd0 && l[2:0] != eb) begin epl[j*3 +: 3] = l[2:0]; got = 1; end
          else if (tries == 7) begin epl[j*3 +: 3] = (eb == 3'd1) ? 3'd2 : 3'd1; got = 1; end
          else tries++;
          l = step(l); cyc++;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] nxt;
    if (reset) nxt = 16'hACE1;
    else if (seed_load) nxt = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
    else nxt = step(m_lfsr);
    @(posedge clk);
    m_lfsr = nxt;
    #1;
  endtask

  // Caller has the DUT idle with start=1 driven in the current cycle.
  task automatic run_round(input string tag, input bit hold_start, input bit pulse, output int lat);
    logic [2:0]  eb, pc;
    logic [1:0]  ep;
    logic [11:0] epl;
    int          ecyc, busy_bad;
    bit          ok;
    predict(step(m_lfsr), m_prev, eb, ep, epl, ecyc);
    tick();
    if (!hold_start) start = 1'b0;
    lat = 0; busy_bad = 0;
    while (!done && lat < 64) begin
      if (busy !== 1'b1) busy_bad++;
      if (pulse) start = ~start;
      tick();
      lat++;
    end
    if (pulse) start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(ecyc));
    check({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, "_done_busy"}, 64'({done, busy}), 64'(2'b10));
    check({tag, "_result"}, 64'({ball, midx, plats}), 64'({eb, ep, epl}));
    ok = (ball != 3'd0) && (ball != m_prev);
    for (int j = 0; j < 4; j++) begin
      pc = plats[j*3 +: 3];
      if (j == int'(midx)) ok = ok && (pc == ball);
      else ok = ok && (pc != 3'd0) && (pc != ball);
    end
    check({tag, "_invariants"}, 64'(ok), 64'd1);
    m_prev = eb;
    idx_seen[midx] = 1'b1;
  endtask

  initial begin
    int   lat, zeros, ret, dn;
    logic [1:0] prev3, pc3;
    bit   ok;

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'hACE1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'hE270};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h7138};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h389C};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h1C4E};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0E27};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'hACE1};
    vecs[7]  = '{1'b0, 1'b1, 16'h0001, 16'h0001};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'hB400};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h5A00};
    vecs[10] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
    vecs[11] = '{1'b1, 1'b1, 16'h5555, 16'hACE1};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'hE270};

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; seed_load = vecs[i].ld; seed_in = vecs[i].sin; start = 1'b0;
      tick();
      check($sformatf("vec%0d_lfsr", i), 64'(lfsr_out), 64'(vecs[i].exp_lfsr));
      check($sformatf("vec%0d_idle_outs", i), 64'({busy, done, ball, plats, midx}), 64'd0);
    end
    reset = 1'b0; seed_load = 1'b0; seed_in = '0;

    seed_load = 1'b1; seed_in = 16'h0001; tick(); seed_load = 1'b0; seed_in = '0;
    check("seed_one", 64'(lfsr_out), 64'h1);
    zeros = 0; ret = 0;
    for (int n = 1; n <= 65535; n++) begin
      tick();
      if (lfsr_out == 16'h0000) zeros++;
      if (ret == 0 && lfsr_out == 16'h0001) ret = n;
    end
    check("free_run_zero_seen", 64'(zeros), 64'd0);
    check("free_run_period", 64'(ret), 64'd65535);
    check("free_run_model_sync", 64'(lfsr_out), 64'(m_lfsr));

    // Hand-traced round from SEED: two rejected balls, one rejected platform draw.
    reset = 1'b1; tick(); reset = 1'b0; m_prev = '0;
    start = 1'b1;
    run_round("single", 1'b0, 1'b0, lat);
    check("single_hand_latency", 64'(lat), 64'd9);
    check("single_hand_ball", 64'(ball), 64'd4);
    check("single_hand_plats", 64'(plats), 64'h45C);
    check("single_hand_idx", 64'(midx), 64'd0);

    // Same LFSR path with previous ball 4: FILL entered after edge E+5, reset while at k=1.
    seed_load = 1'b1; seed_in = 16'h0000; tick(); seed_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("midfill_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0; m_prev = '0;
    check("midfill_reset_outs", 64'({busy, done, ball, plats, midx}), 64'd0);
    dn = 0;
    repeat (20) begin tick(); if (done) dn++; end
    check("midfill_no_done", 64'(dn), 64'd0);

    start = 1'b1;
    run_round("pulsed", 1'b0, 1'b1, lat);
    dn = 0;
    repeat (12) begin tick(); if (done) dn++; end
    check("pulsed_single_done", 64'(dn), 64'd0);

    idx_seen = '0;
    start = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      run_round($sformatf("b2b%0d", r), 1'b1, 1'b0, lat);
    end
    start = 1'b0;
    check("b2b_idx_coverage", 64'(idx_seen), 64'hF);
    repeat (3) tick();

    prev3 = '0;
    start3 = 1'b1;
    for (int r = 0; r < 500; r++) begin
      tick();
      lat = 0;
      while (!done3 && lat < 20) begin tick(); lat++; end
      check($sformatf("p3_latency%0d", r), 64'(lat), 64'd5);
      ok = (ball3 != 2'd0) && (ball3 != prev3) && (midx3 < 2'd3) && !busy3;
      for (int j = 0; j < 3; j++) begin
        pc3 = plats3[j*2 +: 2];
        if (j == int'(midx3)) ok = ok && (pc3 == ball3);
        else ok = ok && (pc3 != 2'd0) && (pc3 != ball3);
      end
      check($sformatf("p3_invariants%0d", r), 64'(ok), 64'd1);
      prev3 = ball3;
    end
    start3 = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
